// File: rtl/othello_pkg.sv
// Shared constants and types for the Othello board renderer.
// Optional grid drawing is enabled by CELL_DRAW_GRID_EN.
package othello_pkg;

  localparam int CELL_SIZE  = 12;
  localparam int CELL_PITCH = 13;
  localparam int ORIGIN_OFF = 9;

  localparam logic [8:0] DISK_R2 = 9'd100;

  localparam logic [1:0] SEL_EMPTY = 2'd0;
  localparam logic [1:0] SEL_BOX   = 2'd1;
  localparam logic [1:0] SEL_WHITE = 2'd2;
  localparam logic [1:0] SEL_BLACK = 2'd3;

  localparam logic [2:0] COL_BOARD  = 3'b010;
  localparam logic [2:0] COL_CURSOR = 3'b110;
  localparam logic [2:0] COL_WHITE  = 3'b111;
  localparam logic [2:0] COL_BLACK  = 3'b000;
  localparam logic [2:0] COL_GRID   = 3'b000;

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

endpackage

// File: rtl/cell_pixel_shader.sv
// Combinational colour lookup for one sprite pixel: cursor outline, disk mask
// and (with CELL_DRAW_GRID_EN) the grid gap row/column.
module cell_pixel_shader
  import othello_pkg::*;
(
  input  logic [3:0] dx_i,
  input  logic [3:0] dy_i,
  input  logic [1:0] sel_i,
  output logic [2:0] colour_o
);

  localparam logic [3:0]        LAST_IDX = 4'(CELL_SIZE - 1);
  localparam logic signed [8:0] CENTRE2  = 9'(CELL_SIZE - 1);

  logic signed [8:0] u, v;
  logic [8:0]        uu, vv, r2;
  logic              onEdge, inDisk;

  // Doubled coordinates keep the sprite centre on an integer grid.
  assign u      = $signed({4'b0000, dx_i, 1'b0}) - CENTRE2;
  assign v      = $signed({4'b0000, dy_i, 1'b0}) - CENTRE2;
  assign uu     = $unsigned(u * u);
  assign vv     = $unsigned(v * v);
  assign r2     = uu + vv;
  assign inDisk = (r2 <= DISK_R2);
  assign onEdge = (dx_i == 4'd0) || (dx_i == LAST_IDX) ||
                  (dy_i == 4'd0) || (dy_i == LAST_IDX);

  always_comb begin
    colour_o = COL_BOARD;
    case (sel_i)
      SEL_BOX:   if (onEdge) colour_o = COL_CURSOR;
      SEL_WHITE: if (inDisk) colour_o = COL_WHITE;
      SEL_BLACK: if (inDisk) colour_o = COL_BLACK;
      default:   colour_o = COL_BOARD;
    endcase
`ifdef CELL_DRAW_GRID_EN
    if ((dx_i == 4'(CELL_SIZE)) || (dy_i == 4'(CELL_SIZE)))
      colour_o = COL_GRID;
`endif
  end

endmodule

// File: rtl/cell_drawer.sv
// Rasterises one cell sprite into the VGA adapter write port, one pixel per clock.
// Defining CELL_DRAW_GRID_EN extends the raster by one grid row/column.
module cell_drawer
  import othello_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic [1:0] select,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

`ifdef CELL_DRAW_GRID_EN
  localparam int RASTER_N = CELL_SIZE + 1;
`else
  localparam int RASTER_N = CELL_SIZE;
`endif
  localparam logic [3:0] LAST = 4'(RASTER_N - 1);

  state_t     state_q;
  logic [3:0] dx_q, dy_q, dx_d, dy_d;
  logic [7:0] xLat_q, xb_d;
  logic [6:0] yLat_q, yb_d;
  logic [1:0] sel_q, sel_d;
  logic [7:0] x_q;
  logic [6:0] y_q;
  logic [2:0] col_q, pixCol;
  logic       plot_q, busy_q, done_q;

  // The output registers always hold the pixel at (dx_q, dy_q), so the shader
  // looks one pixel ahead; on acceptance that is pixel (0,0) of the live inputs.
  always_comb begin
    dx_d  = dx_q;
    dy_d  = dy_q;
    sel_d = sel_q;
    xb_d  = xLat_q;
    yb_d  = yLat_q;
    if (state_q == IDLE) begin
      dx_d  = 4'd0;
      dy_d  = 4'd0;
      sel_d = select;
      xb_d  = x_in;
      yb_d  = y_in;
    end else if (dx_q == LAST) begin
      dx_d = 4'd0;
      dy_d = dy_q + 4'd1;
    end else begin
      dx_d = dx_q + 4'd1;
    end
  end

  cell_pixel_shader u_shader (
    .dx_i     (dx_d),
    .dy_i     (dy_d),
    .sel_i    (sel_d),
    .colour_o (pixCol)
  );

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q <= IDLE;
      dx_q    <= '0;
      dy_q    <= '0;
      xLat_q  <= '0;
      yLat_q  <= '0;
      sel_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      col_q   <= '0;
      plot_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            xLat_q  <= x_in;
            yLat_q  <= y_in;
            sel_q   <= select;
            dx_q    <= 4'd0;
            dy_q    <= 4'd0;
            x_q     <= x_in;
            y_q     <= y_in;
            col_q   <= pixCol;
            plot_q  <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= DRAW;
          end
        end
        DRAW: begin
          if ((dx_q == LAST) && (dy_q == LAST)) begin
            plot_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            dx_q  <= dx_d;
            dy_q  <= dy_d;
            x_q   <= xb_d + 8'(dx_d);
            y_q   <= yb_d + 7'(dy_d);
            col_q <= pixCol;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign x_out  = x_q;
  assign y_out  = y_q;
  assign colour = col_q;
  assign plot   = plot_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_cell_drawer.sv
// Scoreboard bench for cell_drawer: a sprite model queues expected pixels and a
// negedge monitor compares every plotted pixel and the done/busy handshake.
module tb_cell_drawer;

  localparam int N = 12;
`ifdef CELL_DRAW_GRID_EN
  localparam int R    = N + 1;
  localparam bit GRID = 1'b1;
`else
  localparam int R    = N;
  localparam bit GRID = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       start = 1'b0;
  logic [7:0] x_in = '0;
  logic [6:0] y_in = '0;
  logic [1:0] select = '0;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic       plot, busy, done;

  logic [3:0] shDx, shDy;
  logic [1:0] shSel;
  logic [2:0] shCol;

  pix_t expQ[$];
  pix_t monP;
  int   expDone = 0;
  int   checks = 0;
  int   errors = 0;
  logic prevPlot = 1'b0;
  logic prevDone = 1'b0;

  cell_drawer dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .x_in   (x_in),
    .y_in   (y_in),
    .select (select),
    .x_out  (x_out),
    .y_out  (y_out),
    .colour (colour),
    .plot   (plot),
    .busy   (busy),
    .done   (done)
  );

  cell_pixel_shader u_shader (
    .dx_i     (shDx),
    .dy_i     (shDy),
    .sel_i    (shSel),
    .colour_o (shCol)
  );

  always #5 clk = ~clk;

  // Sprite rules written directly as geometry: outline test and circle test.
  function automatic logic [2:0] refColour(int dx, int dy, int sel);
    int u, v;
    if (GRID && (dx == N || dy == N)) return 3'b000;
    u = 2 * dx - (N - 1);
    v = 2 * dy - (N - 1);
    case (sel)
      1: return (dx == 0 || dx == N - 1 || dy == 0 || dy == N - 1) ? 3'b110 : 3'b010;
      2: return (u * u + v * v <= 100) ? 3'b111 : 3'b010;
      3: return (u * u + v * v <= 100) ? 3'b000 : 3'b010;
      default: return 3'b010;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic pushModel(input int xs, input int ys, input int sel);
    pix_t p;
    for (int dy = 0; dy < R; dy++)
      for (int dx = 0; dx < R; dx++) begin
        p.x = 8'(xs + dx);
        p.y = 7'(ys + dy);
        p.c = refColour(dx, dy, sel);
        expQ.push_back(p);
      end
    expDone++;
  endtask

  // Issues one draw; optionally pulses start or asserts reset at a given pixel index.
  task automatic applyStimulus(input int xs, input int ys, input int sel, input int ignoreAt, input int abortAt);
    int   n;
    logic aborted;
    aborted = 1'b0;
    @(posedge clk); #1;
    x_in = 8'(xs); y_in = 7'(ys); select = 2'(sel); start = 1'b1;
    pushModel(xs, ys, sel);
    @(posedge clk); #1;
    start = 1'b0;
    x_in = 8'($urandom); y_in = 7'($urandom); select = 2'($urandom);
    checkOutput("first_plot_latency", {31'd0, plot}, 32'd1);
    checkOutput("busy_on_start", {31'd0, busy}, 32'd1);
    n = 0;
    while (!done && n < 400 && !aborted) begin
      start = (n == ignoreAt);
      if (n == ignoreAt) x_in = 8'(xs + 37);
      if (n == abortAt) begin
        #1 resetn = 1'b1;
        expQ.delete();
        expDone = 0;
        #1;
        checkOutput("abort_plot", {31'd0, plot}, 32'd0);
        checkOutput("abort_x", {24'd0, x_out}, 32'd0);
        checkOutput("abort_y", {25'd0, y_out}, 32'd0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        resetn = 1'b0;
        aborted = 1'b1;
      end else begin
        @(posedge clk); #1;
        n++;
      end
    end
    start = 1'b0;
    if (!aborted) begin
      checkOutput("done_seen", {31'd0, done}, 32'd1);
      checkOutput("draw_cycles", 32'(n), 32'(R * R));
    end
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      prevPlot = 1'b0;
      prevDone = 1'b0;
    end else begin
      if (plot) begin
        if (expQ.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_plot at (%0d,%0d) at %0t", x_out, y_out, $time);
        end else begin
          monP = expQ.pop_front();
          checkOutput("pixel_xyc", {14'd0, x_out, y_out, colour}, {14'd0, monP.x, monP.y, monP.c});
        end
        checkOutput("busy_draw", {31'd0, busy}, 32'd1);
      end else if (prevPlot && !done && expQ.size() != 0) begin
        checks++; errors++;
        $display("[TB] FAIL plot_gap remaining=%0d at %0t", expQ.size(), $time);
      end
      if (done) begin
        if (expDone == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_done at %0t", $time);
        end else expDone--;
        checkOutput("queue_empty_at_done", 32'(expQ.size()), 32'd0);
        checkOutput("plot_before_done", {31'd0, prevPlot}, 32'd1);
        checkOutput("busy_at_done", {31'd0, busy}, 32'd1);
      end
      if (prevDone) begin
        checkOutput("done_width", {31'd0, done}, 32'd0);
        checkOutput("busy_after_done", {31'd0, busy}, 32'd0);
      end
      prevPlot = plot;
      prevDone = done;
    end
  end

  initial begin
    // Exhaustive shader sweep over the raster while the drawer sits in reset.
    for (int s = 0; s < 4; s++)
      for (int dy = 0; dy < R; dy++)
        for (int dx = 0; dx < R; dx++) begin
          shSel = 2'(s); shDy = 4'(dy); shDx = 4'(dx);
          #1;
          checkOutput("shader", {29'd0, shCol}, {29'd0, refColour(dx, dy, s)});
        end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_x", {24'd0, x_out}, 32'd0);
    checkOutput("reset_y", {25'd0, y_out}, 32'd0);
    checkOutput("reset_colour", {29'd0, colour}, 32'd0);
    checkOutput("reset_plot", {31'd0, plot}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    resetn = 1'b0;

    applyStimulus(9, 9, 0, -1, -1);
    applyStimulus(22, 35, 1, -1, -1);
    applyStimulus(9, 9, 2, -1, -1);
    applyStimulus(9, 9, 3, -1, -1);
    applyStimulus(40, 20, 2, 50, -1);
    applyStimulus(60, 60, 3, -1, 70);
    repeat (4) @(posedge clk);
    applyStimulus(60, 60, 3, -1, -1);
    applyStimulus(250, 125, 1, -1, -1);

    for (int i = 0; i < 6; i++)
      applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                    int'($urandom_range(0, 3)), -1, -1);

    repeat (4) @(posedge clk);
    checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);
    checkOutput("final_done_balance", 32'(expDone), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cell_drawer.md
Name: cell_drawer

Overview:
- Sits directly downstream of the board datapath.
- Consumes a cell's top-left pixel coordinate (x, y) and a 2-bit select code, and rasterises that cell sprite as a stream of single-pixel writes into the VGA adapter's write port (x, y, colour, plot).
- Raises busy while drawing and pulses done when finished, so the control FSM can sequence erase-old-cursor, draw-new-cursor and place-disk operations.

Parameters:
- CELL_SIZE, 12: sprite edge in pixels; board pitch is 13, leaving a 1-pixel gap.
- DISK_R2, 100: disk threshold in doubled coordinates, i.e. (2·radius)².
- COL_BOARD, 3'b010: board background colour (green).
- COL_CURSOR, 3'b110: cursor box outline colour (yellow).
- COL_WHITE, 3'b111: white disk colour.
- COL_BLACK, 3'b000: black disk colour.
- COL_GRID, 3'b000: grid line colour (used only with the optional feature).

Ports:
- clk  in  1  system clock, all state on rising edge.
- resetn  in  1  asynchronous, active-high reset (despite the name).
- start  in  1  request pulse; sampled only in IDLE.
- x_in  in  8  cell top-left x.
- y_in  in  7  cell top-left y.
- select  in  2  0 empty, 1 cursor box, 2 white disk, 3 black disk.
- x_out  out  8  pixel x to VGA adapter.
- y_out  out  7  pixel y to VGA adapter.
- colour  out  3  pixel colour.
- plot  out  1  pixel write enable.
- busy  out  1  high from the cycle after start acceptance through the DONE state.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: state=IDLE; x_out=0, y_out=0, colour=0, plot=0, busy=0, done=0; counters dx=dy=0; latched inputs cleared.
- Reset asserted mid-draw aborts immediately to IDLE. No further plot pulses occur, and no done pulse is issued.
- FSM:
  - IDLE: on start=1, latch x_in, y_in, select; clear dx, dy; go to DRAW. Inputs are not re-sampled afterwards.
  - DRAW: each cycle output one registered pixel with plot=1, x_out=x_lat+dx, y_out=y_lat+dy (mod 256 / mod 128, no saturation).
    - Raster order is dx fastest, then dy.
    - After pixel (N-1, N-1), where N=CELL_SIZE, go to DONE.
  - DONE: plot=0, done=1 for exactly one cycle, busy=1; next state IDLE.
- Latency:
  - First plot pulse appears the cycle after start is accepted.
  - Exactly N² consecutive plot cycles (144 by default), no gaps.
  - done follows one cycle after the last pixel.
- start while not in IDLE (DRAW or DONE) is ignored and not queued. start held high in IDLE after DONE begins a new draw.
- Colour rule per pixel, with u=2·dx−(N−1) and v=2·dy−(N−1) as signed 6-bit values:
  - select 0: COL_BOARD.
  - select 1: COL_CURSOR when dx==0, dx==N−1, dy==0 or dy==N−1; otherwise COL_BOARD.
  - select 2/3: COL_WHITE / COL_BLACK when u²+v² ≤ DISK_R2 (unsigned 9-bit compare); otherwise COL_BOARD.
- Outputs are registered. When plot=0, x_out, y_out and colour hold their last value.

Optional Feature:
- Macro CELL_DRAW_GRID_EN.
  - Defined: raster spans (N+1)×(N+1) = 169 pixels. Column dx==N and row dy==N are drawn in COL_GRID, overriding select. done arrives after pixel (N, N).
  - Undefined: N×N raster only, grid gap untouched, 144 pixels.

Decomposition:
- Package othello_pkg holds:
  - select encoding constants SEL_EMPTY, SEL_BOX, SEL_WHITE, SEL_BLACK;
  - colour constants;
  - cell pitch 13 and origin offset 9 (shared with the datapath);
  - FSM state typedef {IDLE, DRAW, DONE}.
- One combinational sub-module, cell_pixel_shader (dx, dy, select -> colour), holds the outline, disk and grid rules so the bench can check it exhaustively in isolation.

Test Plan:
- Reset, then start with x_in=9, y_in=9, select=0 -> 144 plot cycles starting one cycle after start. Coordinates run x=9..20 per row, rows y=9..20. All colour=010. done pulse one cycle after the pixel at (20, 20); busy returns low with done.
- select=1 at x_in=22, y_in=35 -> pixels (22,35), (33,35), (22,46), (33,46) and every edge pixel are 110; pixel (23,36) is 010.
- select=2 at x_in=9, y_in=9 -> (9,9)=010 [u²+v²=242]; (14,14)=111 [2]; (9,14)=010 [122]; (10,14)=111 [82]. select=3 gives the same mask with colour 000.
- start pulsed again at DRAW pixel 50 with different x_in -> ignored; coordinates continue from the original latch; total plot count stays 144.
- resetn asserted at DRAW pixel 70 -> plot=0 in the same time step (asynchronous); no done; x_out=y_out=0. A new start after release draws a full sprite.
- With CELL_DRAW_GRID_EN defined, select=0 at (9,9) -> 169 plot cycles. (21, y) and (x, 21) are 000; (20,20)=010.
